// File: rtl/dem_ngay_thang_nam.sv
// Calendar date counter and editor: keeps a BCD day/month/year (20xx),
// advances on the daily rollover pulse and offers a three-field button
// editor with month-length and leap-year awareness.
module dem_ngay_thang_nam #(
    parameter logic [7:0] NGAY_RESET  = 8'h01,
    parameter logic [7:0] THANG_RESET = 8'h01,
    parameter logic [7:0] NAM_RESET   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ngay,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] ngay,
    output logic [7:0] thang,
    output logic [7:0] nam,
    output logic [1:0] che_do,
    output logic [2:0] nhay,
    output logic       nam_tran
);

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] SET_NGAY  = 2'd1;
    localparam logic [1:0] SET_THANG = 2'd2;
    localparam logic [1:0] SET_NAM   = 2'd3;

    logic [7:0] ngay_q, ngay_d;
    logic [7:0] thang_q, thang_d;
    logic [7:0] nam_q, nam_d;
    logic [1:0] che_do_q, che_do_d;
    logic [2:0] nhay_q, nhay_d;
    logic       nam_tran_q, nam_tran_d;

    logic       step_up;
    logic       step_down;
    logic [7:0] maxd_cur;

    logic [7:0] roll_ngay;
    logic [7:0] roll_thang;
    logic [7:0] roll_nam;
    logic       roll_wrap;

    logic [7:0] edit_ngay;
    logic [7:0] edit_thang;
    logic [7:0] edit_nam;
    logic [7:0] maxd_edit;
    logic [7:0] clamp_ngay;

    // Two-digit BCD increment; units carry into tens, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    // Two-digit BCD decrement; units borrow from tens, 00 wraps to 99.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = (v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1;
        end else begin
            r[3:0] = v[3:0] - 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    // Divisible-by-4 test done directly on the BCD digits: an even tens
    // digit needs units 0/4/8, an odd tens digit needs units 2/6.
    function automatic logic is_leap(input logic [7:0] y);
        logic leap;
        if (y[4] == 1'b0) begin
            leap = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
        end else begin
            leap = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
        end
        return leap;
    endfunction

    // Last legal day (BCD) of the given month in the given year.
    function automatic logic [7:0] max_day(input logic [7:0] m, input logic [7:0] y);
        logic [7:0] d;
        case (m)
            8'h02:                      d = is_leap(y) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

    // Edit-state sequencing and the matching blink select.
    always_comb begin
        che_do_d = che_do_q;
        if (btn_mode) begin
            che_do_d = (che_do_q == SET_NAM) ? RUN : che_do_q + 2'd1;
        end
        case (che_do_d)
            SET_NGAY:  nhay_d = 3'b001;
            SET_THANG: nhay_d = 3'b010;
            SET_NAM:   nhay_d = 3'b100;
            default:   nhay_d = 3'b000;
        endcase
    end

    // Daily rollover: next day, or first of next month, or new year.
    always_comb begin
        maxd_cur   = max_day(thang_q, nam_q);
        roll_ngay  = ngay_q;
        roll_thang = thang_q;
        roll_nam   = nam_q;
        roll_wrap  = 1'b0;
        if (ngay_q < maxd_cur) begin
            roll_ngay = bcd_inc(ngay_q);
        end else begin
            roll_ngay = 8'h01;
            if (thang_q == 8'h12) begin
                roll_thang = 8'h01;
                roll_nam   = bcd_inc(nam_q);
                roll_wrap  = (nam_q == 8'h99);
            end else begin
                roll_thang = bcd_inc(thang_q);
            end
        end
    end

    // Field edits with wraparound; a month or year change clamps the day
    // in the same cycle so an illegal date never reaches the outputs.
    always_comb begin
        step_up    = btn_up & ~btn_down & ~btn_mode;
        step_down  = btn_down & ~btn_up & ~btn_mode;
        edit_ngay  = ngay_q;
        edit_thang = thang_q;
        edit_nam   = nam_q;
        if (step_up) begin
            edit_ngay  = (ngay_q >= maxd_cur) ? 8'h01 : bcd_inc(ngay_q);
            edit_thang = (thang_q == 8'h12) ? 8'h01 : bcd_inc(thang_q);
            edit_nam   = bcd_inc(nam_q);
        end else if (step_down) begin
            edit_ngay  = (ngay_q == 8'h01) ? maxd_cur : bcd_dec(ngay_q);
            edit_thang = (thang_q == 8'h01) ? 8'h12 : bcd_dec(thang_q);
            edit_nam   = bcd_dec(nam_q);
        end
        if (che_do_q == SET_THANG) begin
            maxd_edit = max_day(edit_thang, nam_q);
        end else begin
            maxd_edit = max_day(thang_q, edit_nam);
        end
        clamp_ngay = (ngay_q > maxd_edit) ? maxd_edit : ngay_q;
    end

    // Select which candidate date becomes the next state for this mode.
    always_comb begin
        ngay_d     = ngay_q;
        thang_d    = thang_q;
        nam_d      = nam_q;
        nam_tran_d = 1'b0;
        case (che_do_q)
            RUN: begin
                if (tick_ngay) begin
                    ngay_d     = roll_ngay;
                    thang_d    = roll_thang;
                    nam_d      = roll_nam;
                    nam_tran_d = roll_wrap;
                end
            end
            SET_NGAY: begin
                ngay_d = edit_ngay;
            end
            SET_THANG: begin
                thang_d = edit_thang;
                ngay_d  = clamp_ngay;
            end
            default: begin
                nam_d  = edit_nam;
                ngay_d = clamp_ngay;
            end
        endcase
    end

    // State registers; reset aborts any edit and restores the reset date.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ngay_q     <= NGAY_RESET;
            thang_q    <= THANG_RESET;
            nam_q      <= NAM_RESET;
            che_do_q   <= RUN;
            nhay_q     <= 3'b000;
            nam_tran_q <= 1'b0;
        end else begin
            ngay_q     <= ngay_d;
            thang_q    <= thang_d;
            nam_q      <= nam_d;
            che_do_q   <= che_do_d;
            nhay_q     <= nhay_d;
            nam_tran_q <= nam_tran_d;
        end
    end

    assign ngay     = ngay_q;
    assign thang    = thang_q;
    assign nam      = nam_q;
    assign che_do   = che_do_q;
    assign nhay     = nhay_q;
    assign nam_tran = nam_tran_q;

endmodule
